// File: rtl/rmii_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : rmii_rx_frame
// Brief    : RMII 100 Mb/s receive framer: preamble/SFD strip, byte assembly,
//            CRC-32/length check, 32-bit payload word capture, frame counters.
//            Optional build macro RMII_RX_ADDR_FILTER_EN enables dest-MAC filtering.
// Revision : 1.0 - initial release
// ============================================================================
module rmii_rx_frame #(
    parameter int          DATA_OFFSET = 14,
    parameter int          MIN_LEN     = 64,
    parameter int          MAX_LEN     = 1518,
    parameter int          PRE_MAX     = 32,
    parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_02_03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rxd,
    input  logic        crs_dv,
    input  logic        rx_er,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] good_cnt,
    output logic [7:0]  err_cnt
);
    localparam int c_CNT_W = $clog2(MAX_LEN + 2);
    localparam int c_PRE_W = $clog2(PRE_MAX + 2);
    localparam logic [c_CNT_W-1:0] c_OFF_LO  = c_CNT_W'(DATA_OFFSET);
    localparam logic [c_CNT_W-1:0] c_OFF_HI  = c_CNT_W'(DATA_OFFSET + 4);
    localparam logic [c_CNT_W-1:0] c_MIN     = c_CNT_W'(MIN_LEN);
    localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_LEN);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRE_MAX);
    localparam logic [31:0] c_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] c_CRC_RESIDUE = 32'hC704_DD7B;

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_END, S_DROP} state_t;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? c_CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           rxd_q;
    logic                 crs_q, er_q, smp_vld_q;
    logic                 armed_q, armed_d;
    logic [c_PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic                 seen01_q, seen01_d;
    logic [1:0]           phase_q, phase_d;
    logic [5:0]           byte_q, byte_d;
    logic [c_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]          crc_q, crc_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [2:0]           shadow_n_q, shadow_n_d;
    logic                 err_q, err_d, low_q, low_d;
    logic [31:0]          data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d, frame_ok_q, frame_ok_d;
    logic                 frame_err_q, frame_err_d;
    logic [15:0]          good_cnt_q, good_cnt_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 mac_local_q, mac_local_d, mac_bcast_q, mac_bcast_d;
    logic [7:0]           w_byte, w_mac_byte;
    logic                 w_good, w_addr_ok, w_align;

`ifdef RMII_RX_ADDR_FILTER_EN
    always_comb begin
        w_mac_byte = 8'h00;
        case (byte_cnt_q[2:0])
            3'd0:    w_mac_byte = LOCAL_MAC[47:40];
            3'd1:    w_mac_byte = LOCAL_MAC[39:32];
            3'd2:    w_mac_byte = LOCAL_MAC[31:24];
            3'd3:    w_mac_byte = LOCAL_MAC[23:16];
            3'd4:    w_mac_byte = LOCAL_MAC[15:8];
            default: w_mac_byte = LOCAL_MAC[7:0];
        endcase
    end
    assign w_addr_ok = mac_local_q | mac_bcast_q;
`else
    logic w_unused_mac;
    assign w_unused_mac = ^{LOCAL_MAC, mac_local_q, mac_bcast_q, w_mac_byte};
    assign w_mac_byte   = 8'h00;
    assign w_addr_ok    = 1'b1;
`endif

    assign w_byte = {rxd_q, byte_q};

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | (smp_vld_q & ~crs_q);
        pre_cnt_d    = pre_cnt_q;
        seen01_d     = seen01_q;
        phase_d      = phase_q;
        byte_d       = byte_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        shadow_d     = shadow_q;
        shadow_n_d   = shadow_n_q;
        err_d        = err_q;
        low_d        = low_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        good_cnt_d   = good_cnt_q;
        err_cnt_d    = err_cnt_q;
        mac_local_d  = mac_local_q;
        mac_bcast_d  = mac_bcast_q;
        w_align      = phase_q != 2'd0;
        w_good       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // After reset, wait for carrier to drop so a frame already in flight is ignored
                if (crs_q && armed_q) begin
                    state_d   = S_PREAMBLE;
                    pre_cnt_d = '0;
                    seen01_d  = 1'b0;
                end
            end
            S_PREAMBLE: begin
                pre_cnt_d = pre_cnt_q + 1'b1;
                if (!crs_q) begin
                    state_d = S_IDLE;
                end else if (rxd_q == 2'b11 && seen01_q) begin
                    state_d     = S_DATA;
                    phase_d     = 2'd0;
                    byte_cnt_d  = '0;
                    crc_d       = c_CRC_INIT;
                    shadow_n_d  = 3'd0;
                    err_d       = 1'b0;
                    low_d       = 1'b0;
                    mac_local_d = 1'b1;
                    mac_bcast_d = 1'b1;
                end else if (pre_cnt_q >= c_PRE_MAX) begin
                    state_d = S_DROP;
                end else if (rxd_q == 2'b01) begin
                    seen01_d = 1'b1;
                end else if (!(rxd_q == 2'b00 && !seen01_q)) begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (er_q) err_d = 1'b1;
                if (!crs_q && (phase_q == 2'd0 || low_q)) begin
                    state_d = S_END;
                    w_good  = (bit_rev32(crc_q) == c_CRC_RESIDUE) && (byte_cnt_q >= c_MIN) &&
                              (byte_cnt_q <= c_MAX) && !err_d && !w_align && (shadow_n_q == 3'd4);
                    if (w_addr_ok) begin
                        if (w_good) begin
                            frame_ok_d   = 1'b1;
                            data_valid_d = 1'b1;
                            data_out_d   = shadow_q;
                            good_cnt_d   = good_cnt_q + 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    // A lone low crs_dv mid-byte is RMII carrier toggling; the dibit is still data
                    low_d   = !crs_q;
                    crc_d   = crc_dibit(crc_q, rxd_q);
                    byte_d  = w_byte[7:2];
                    phase_d = phase_q + 1'b1;
                    if (phase_q == 2'd3) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q >= c_OFF_LO && byte_cnt_q < c_OFF_HI) begin
                            shadow_d   = {shadow_q[23:0], w_byte};
                            shadow_n_d = shadow_n_q + 1'b1;
                        end
                        if (byte_cnt_q < c_CNT_W'(6)) begin
                            if (w_byte != w_mac_byte) mac_local_d = 1'b0;
                            if (w_byte != 8'hFF)      mac_bcast_d = 1'b0;
                        end
                        if (byte_cnt_q >= c_MAX) begin
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end
                end
            end
            S_END: state_d = S_IDLE;
            S_DROP: begin
                if (!crs_q) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rxd_q        <= 2'b00;
            crs_q        <= 1'b0;
            er_q         <= 1'b0;
            smp_vld_q    <= 1'b0;
            armed_q      <= 1'b0;
            pre_cnt_q    <= '0;
            seen01_q     <= 1'b0;
            phase_q      <= 2'd0;
            byte_q       <= 6'd0;
            byte_cnt_q   <= '0;
            crc_q        <= c_CRC_INIT;
            shadow_q     <= 32'h0;
            shadow_n_q   <= 3'd0;
            err_q        <= 1'b0;
            low_q        <= 1'b0;
            data_out_q   <= 32'h0;
            data_valid_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            good_cnt_q   <= 16'h0;
            err_cnt_q    <= 8'h0;
            mac_local_q  <= 1'b0;
            mac_bcast_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rxd_q        <= rxd;
            crs_q        <= crs_dv;
            er_q         <= rx_er;
            smp_vld_q    <= 1'b1;
            armed_q      <= armed_d;
            pre_cnt_q    <= pre_cnt_d;
            seen01_q     <= seen01_d;
            phase_q      <= phase_d;
            byte_q       <= byte_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            shadow_q     <= shadow_d;
            shadow_n_q   <= shadow_n_d;
            err_q        <= err_d;
            low_q        <= low_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
            mac_local_q  <= mac_local_d;
            mac_bcast_q  <= mac_bcast_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign busy       = state_q != S_IDLE;
    assign good_cnt   = good_cnt_q;
    assign err_cnt    = err_cnt_q;
endmodule
`default_nettype wire

// File: doc/rmii_rx_frame.md
Name: rmii_rx_frame

Overview:
- RMII 100 Mb/s receive-side framer: the receive counterpart of the team's RMII frame transmitter.
- Samples RXD[1:0]/CRS_DV on the 50 MHz reference clock, strips preamble/SFD, assembles bytes and checks FCS (CRC-32) and length.
- Extracts one 32-bit payload word at a fixed frame offset and presents it to the seven-segment/data path with a one-cycle valid strobe.
- Also keeps good/bad frame counters.

Parameters:
- DATA_OFFSET, 14: byte index (0 = first destination-MAC byte) of the first payload byte captured.
- MIN_LEN, 64: minimum frame length in bytes including FCS.
- MAX_LEN, 1518: maximum frame length in bytes including FCS.
- PRE_MAX, 32: maximum dibits allowed between CRS_DV rise and SFD.
- LOCAL_MAC, 48'h00_0A_35_01_02_03: station address (used only with the optional feature).

Ports:
- clk  in  1  50 MHz RMII reference clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  2  RMII receive dibit; rxd[0] is the earlier bit.
- crs_dv  in  1  RMII carrier sense / data valid.
- rx_er  in  1  PHY receive error.
- data_out  out  32  last captured payload word.
- data_valid  out  1  one-cycle strobe; data_out updated this cycle.
- frame_ok  out  1  one-cycle strobe on good-frame end.
- frame_err  out  1  one-cycle strobe on bad-frame end.
- busy  out  1  high while state is not IDLE.
- good_cnt  out  16  good-frame counter; wraps at 0xFFFF→0.
- err_cnt  out  8  bad-frame counter; saturates at 0xFF.

Behaviour:
- Reset: every output 0, state IDLE, CRC register 0xFFFFFFFF. Reset mid-frame abandons the frame; receive restarts on the next CRS_DV rise.
- Inputs are registered once before use, so all latencies below are counted from the registered sample.
- IDLE: crs_dv=1 → PREAMBLE; preamble dibit counter cleared.
- PREAMBLE:
  - rxd=00 is accepted only before the first 01.
  - rxd=01 is counted.
  - rxd=11 after at least one 01 → DATA; dibit phase 0, byte count 0, CRC preset to 0xFFFFFFFF.
  - Any other dibit, or the counter exceeding PRE_MAX → DROP.
  - crs_dv=0 → IDLE, silently (no strobes).
- DATA:
  - One dibit per cycle, LSB-first: dibit n of a byte fills bits [2n+1:2n]. The byte completes at phase 3.
  - CRC-32 (poly 0x04C11DB7, reflected) updates 2 bits per cycle over every dibit, including the FCS.
  - Bytes DATA_OFFSET..DATA_OFFSET+3 go into a shadow register, big-endian: byte DATA_OFFSET → bits [31:24].
  - rx_er=1 at any cycle sets a sticky error flag.
  - Byte count exceeding MAX_LEN sets the error flag → DROP.
- End of frame, decided in DATA:
  - crs_dv=0 at phase 0 → END.
  - crs_dv=0 at phase ≠0 is treated as RMII CRS_DV toggling: the dibit is still accepted.
  - A second consecutive crs_dv=0 → END with an alignment error.
- END (one cycle), then IDLE. The frame is good only if all hold: CRC residue = 0xC704DD7B, MIN_LEN ≤ bytes ≤ MAX_LEN, no rx_er, no alignment error, and the shadow word complete.
  - Good frame: frame_ok=1, data_valid=1, data_out ← shadow, good_cnt+1.
  - Bad frame: frame_err=1, err_cnt+1 (saturating), data_out unchanged.
  - Strobes are high exactly one cycle, 1 cycle after the terminating crs_dv=0 sample.
- DROP: waits for crs_dv=0, then pulses frame_err, increments err_cnt, and returns to IDLE. DROP entered from PREAMBLE on a bad dibit counts; a PREAMBLE timeout also counts.
- crs_dv rising in the END cycle is ignored. IDLE then requires crs_dv=1 to begin the next frame; back-to-back frames with 1 cycle of gap must be received.

Optional Feature:
- Macro: RMII_RX_ADDR_FILTER_EN.
- Defined: destination bytes 0–5 are compared against LOCAL_MAC and FF:FF:FF:FF:FF:FF. A frame matching neither is discarded silently at END: no strobes, no counter change, data_out unchanged.
- Undefined: no address comparison; every frame is judged on CRC, length and errors only.

Test Plan:
- 64-byte valid frame, bytes 14–17 = 12 34 56 78, correct FCS → data_out=0x12345678, data_valid and frame_ok high 1 cycle, good_cnt=1, err_cnt=0.
- Same frame with one FCS bit flipped → frame_err 1 cycle, err_cnt=1, data_out keeps its previous value, no data_valid.
- 40-byte frame with valid CRC → frame_err (runt), err_cnt+1. 1519-byte frame → DROP, frame_err after crs_dv falls.
- rx_er pulsed at byte 30 of an otherwise valid frame → frame_err. A following valid frame with payload 0xCAFEBABE, 1 idle cycle later → data_out=0xCAFEBABE.
- Reset asserted at byte 20 of a frame → all outputs 0 immediately; the rest of that frame gives no strobes; the next valid frame is received normally.
- With RMII_RX_ADDR_FILTER_EN: valid frame with destination 00:11:22:33:44:55 → no strobes, counters unchanged. Broadcast destination → frame_ok.
